// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-line bundle for serial_bit_feeder.
// The slave modport is the feeder side; the master modport is the word source / line consumer.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport slave (
    input  clr,
    input  en,
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    output ser_valid,
    output word_done,
    output busy
  );

  modport master (
    output clr,
    output en,
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done,
    input  busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the serial sequence detectors.
// A one-word holding buffer in front of the shifter lets words stream back to back; with nothing
// to send the line sits at IDLE_BIT so a detector downstream never sees a spurious pattern.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  serial_bit_feeder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_hold;
  logic              r_hold_valid;
  logic [WIDTH-1:0]  r_sh;
  logic [CntW-1:0]   r_cnt;

  logic              w_last;
  logic              w_accept;
  logic [WIDTH-1:0]  w_sh_next;

  // Decode last-bit, accept and the one-position shift toward the output end.
  always_comb begin
    w_last   = (r_state == StShift) && bus.en && (r_cnt == LastCnt);
    w_accept = bus.in_valid && !r_hold_valid;
    if (MSB_FIRST) begin
      w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
    end else begin
      w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
    end
  end

  // Holding buffer, shifter, bit counter and state; clr outranks accept and shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_sh         <= '0;
      r_cnt        <= '0;
    end else if (bus.clr) begin
      r_state      <= StIdle;
      r_hold_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Loading from the buffer does not wait for en.
          if (r_hold_valid) begin
            r_sh         <= r_hold;
            r_cnt        <= '0;
            r_hold_valid <= 1'b0;
            r_state      <= StShift;
          end
        end
        StShift: begin
          if (w_last) begin
            if (r_hold_valid) begin
              // Reload straight from the buffer so consecutive words have no gap.
              r_sh         <= r_hold;
              r_cnt        <= '0;
              r_hold_valid <= 1'b0;
            end else begin
              r_cnt   <= '0;
              r_state <= StIdle;
            end
          end else if (bus.en) begin
            r_sh  <= w_sh_next;
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
      // Accept only when the buffer is empty, so it never collides with a transfer above.
      if (w_accept) begin
        r_hold       <= bus.in_data;
        r_hold_valid <= 1'b1;
      end
    end
  end

  // Output decode from registered state only; in_ready has no path from in_valid.
  always_comb begin
    bus.in_ready  = !r_hold_valid;
    bus.busy      = (r_state == StShift) || r_hold_valid;
    bus.word_done = w_last;
    if (r_state == StShift) begin
      bus.ser_out   = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
      bus.ser_valid = 1'b1;
    end else begin
      bus.ser_out   = IDLE_BIT;
      bus.ser_valid = 1'b0;
    end
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial stage that sits directly upstream of the team's serial sequence-detector FSMs. It accepts parallel words over a valid/ready handshake and drives one bit per enabled clock on a single serial line, which feeds a detector's x input. A one-word holding buffer lets back-to-back words stream with no idle gap. When no data is available, the line is held at a fixed idle level that cannot form a detector pattern.

Parameters:
WIDTH, 8, word width in bits (2..32)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 0, level driven on ser_out when no word is being shifted

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
clr  input  1  synchronous flush; drops the holding buffer and any word in flight
en  input  1  shift enable; when 0 the shifter and bit counter hold their values
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  parallel word
ser_out  output  1  serial bit (connects to the detector's x)
ser_valid  output  1  ser_out carries a data bit (not idle fill)
word_done  output  1  one-cycle pulse on the cycle the last bit of a word is driven with en=1
busy  output  1  shifter active or holding buffer occupied

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hold_valid=0, shift register=0, bit count=0. Outputs: in_ready=1, ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0. Reset asserted mid-word aborts the word immediately; no further bits of it are driven.
- Storage: holding register hold[WIDTH-1:0] with hold_valid, shift register sh[WIDTH-1:0], bit counter cnt of width clog2(WIDTH).
- in_ready = !hold_valid. This is a registered-state decode with no combinational path from in_valid.
- Accept: when in_valid=1 and in_ready=1 at a rising edge, hold<=in_data and hold_valid<=1. When in_ready=0, in_data is ignored and the upstream source must hold it.
- State IDLE: ser_out=IDLE_BIT, ser_valid=0. If hold_valid=1, the next edge loads sh<=hold, sets cnt<=0, clears hold_valid and enters SHIFT. This load is independent of en.
- State SHIFT: ser_out = sh[WIDTH-1] when MSB_FIRST=1, else sh[0]; ser_valid=1.
  - When en=1, each edge shifts sh by one position toward the output end and increments cnt.
  - When en=0, sh and cnt hold, and ser_out/ser_valid stay stable.
- Last bit: cnt==WIDTH-1 with en=1.
  - word_done=1 combinationally during that cycle.
  - If hold_valid=1, the next edge reloads sh from hold, sets cnt<=0, clears hold_valid and stays in SHIFT, so there is no gap between words.
  - Otherwise the next edge moves to IDLE.
- Latency: word accepted at edge N; first bit visible on ser_out after edge N+1.
- Throughput: one word per WIDTH enabled cycles, sustained.
- Simultaneous accept and transfer cannot occur, because accept requires hold_valid=0 and transfer requires hold_valid=1. A new word is accepted one cycle after the buffer drains.
- clr=1 at an edge: hold_valid<=0, state<=IDLE, cnt<=0. clr has priority over accept and over shifting; in_data presented in that cycle is dropped.
- busy = (state==SHIFT) or hold_valid.
- en=0 in IDLE has no effect on accept or on the IDLE-to-SHIFT load.

Test Plan:
- Reset, then hold in_valid=0: ser_out=0, ser_valid=0, in_ready=1 for 20 cycles; a downstream detector's z never asserts.
- WIDTH=8, MSB_FIRST=1, send 8'hA0 with en=1 → ser_out carries 1,0,1,0,0,0,0,0 on cycles N+1..N+8; word_done pulses on N+8; the detector's z is high exactly one cycle after the third bit.
- Back-to-back 8'hFF then 8'h00 with in_valid held high → 16 consecutive ser_valid cycles with no gap; in_ready deasserts while the buffer is full.
- Same as the 8'hA0 case but with en=0 for cycles N+3..N+5 → bit 3 held stable for 3 extra cycles, bit order unchanged, word_done delayed by 3 cycles.
- MSB_FIRST=0, send 8'h05 → ser_out sequence 1,0,1,0,0,0,0,0.
- Assert clr at bit 4 of a word with a second word buffered → ser_out=IDLE_BIT next cycle, busy=0, in_ready=1, the buffered word is never transmitted. Repeat with rst pulsed low mid-word → same result, applied asynchronously.
